// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment / absolute / PC-relative update under an IDLE-RUN-HALT FSM.
// Latency: prog_ctr updates one cycle after the decision; lut_addr is a zero-cycle pass-through.
// No backpressure; stall holds the PC in RUN. Optional macro PC_LINK_EN adds a one-entry call/return link.
module pc_sequencer #(
  parameter int          D        = 10,
  parameter int unsigned START_PC = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         branch_en,
  input  logic         rel_mode,
  input  logic [3:0]   lut_idx,
  input  logic         halt_req,
`ifdef PC_LINK_EN
  input  logic         call_en,
  input  logic         ret_en,
`endif
  output logic [3:0]   lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done
);

  localparam logic [D-1:0] START_V = START_PC[D-1:0];
  localparam logic [D-1:0] PC_ONE  = {{(D-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
`ifdef PC_LINK_EN
  logic [D-1:0]   link_q, link_d;
`endif

  // Table index is a straight wire from the instruction field.
  assign lut_addr = lut_idx;
  assign prog_ctr = pc_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == HALT);

  // Next state and next PC: in RUN, halt beats stall beats (return) beats branch beats increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_LINK_EN
    link_d  = link_q;
`endif
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_V;
        end
      end
      RUN: begin
        if (halt_req) begin
          // PC keeps the halting instruction's address.
          state_d = HALT;
        end else if (stall) begin
          // A branch coincident with a stall is dropped; the decoder reasserts it.
          pc_d = pc_q;
        end
`ifdef PC_LINK_EN
        else if (ret_en) begin
          pc_d = link_q;
        end
`endif
        else if (branch_en) begin
          // Relative mode treats the target as two's complement; the D-bit add wraps naturally.
          pc_d = rel_mode ? (pc_q + lut_target) : lut_target;
`ifdef PC_LINK_EN
          if (call_en) begin
            link_d = pc_q + PC_ONE;
          end
`endif
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_V;
      end
    endcase
  end

  // State, PC and link registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_V;
`ifdef PC_LINK_EN
      link_q  <= START_V;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_LINK_EN
      link_q  <= link_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam int D        = 10;
  localparam int START_PC = 0;
  localparam int MODULUS  = 1 << D;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic         branch_en = 1'b0;
  logic         rel_mode = 1'b0;
  logic [3:0]   lut_idx = 4'd0;
  logic         halt_req = 1'b0;
  logic         call_en = 1'b0;
  logic         ret_en = 1'b0;
  logic [3:0]   lut_addr;
  logic [D-1:0] lut_target = '0;
  logic [D-1:0] prog_ctr;
  logic         running;
  logic         done;

  // Behavioural model: plain integers and two flags.
  int  exp_pc   = START_PC;
  int  exp_link = START_PC;
  bit  exp_run  = 1'b0;
  bit  exp_done = 1'b0;
  logic [D-1:0] exp_pc_v;

  int vectors = 0;
  int errors  = 0;

  pc_sequencer #(.D(D), .START_PC(START_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .branch_en  (branch_en),
    .rel_mode   (rel_mode),
    .lut_idx    (lut_idx),
    .halt_req   (halt_req),
`ifdef PC_LINK_EN
    .call_en    (call_en),
    .ret_en     (ret_en),
`endif
    .lut_addr   (lut_addr),
    .lut_target (lut_target),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Advance the model by one cycle from the current inputs, then clock the DUT and settle.
  task automatic tick();
    int tgt;
    tgt = int'(lut_target);
    if (reset) begin
      exp_pc   = START_PC;
      exp_run  = 1'b0;
      exp_done = 1'b0;
      exp_link = START_PC;
    end else if (!exp_run) begin
      if (start) begin
        exp_pc   = START_PC;
        exp_run  = 1'b1;
        exp_done = 1'b0;
      end
    end else if (halt_req) begin
      exp_run  = 1'b0;
      exp_done = 1'b1;
    end else if (stall) begin
      exp_pc = exp_pc;
`ifdef PC_LINK_EN
    end else if (ret_en) begin
      exp_pc = exp_link;
`endif
    end else if (branch_en) begin
`ifdef PC_LINK_EN
      if (call_en) exp_link = (exp_pc + 1) % MODULUS;
`endif
      exp_pc = rel_mode ? (exp_pc + tgt) % MODULUS : tgt;
    end else begin
      exp_pc = (exp_pc + 1) % MODULUS;
    end
    exp_pc_v = exp_pc[D-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
    rel_mode = 1'b0; halt_req = 1'b0; call_en = 1'b0; ret_en = 1'b0;
  endtask

  // Absolute branch to a given PC (assumes RUN), no checking here.
  task automatic jump_to(input int pc);
    clr();
    branch_en = 1'b1;
    lut_target = pc[D-1:0];
    tick();
    clr();
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (prog_ctr !== exp_pc_v || running !== exp_run || done !== exp_done) begin
      errors++;
      $display("FAIL reset: pc=%0d run=%0b done=%0b, want pc=%0d run=%0b done=%0b",
               prog_ctr, running, done, exp_pc_v, exp_run, exp_done);
    end
    clr();
  endtask

  task automatic test_increment();
    clr();
    start = 1'b1;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || running !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start: pc=%0d run=%0b done=%0b, want pc=%0d run=1 done=0",
               prog_ctr, running, done, exp_pc_v);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (prog_ctr !== exp_pc_v || running !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL increment[%0d]: pc=%0d run=%0b done=%0b, want pc=%0d run=1 done=0",
                 i, prog_ctr, running, done, exp_pc_v);
      end
    end
  endtask

  task automatic test_abs_branch();
    jump_to(7);
    branch_en = 1'b1; rel_mode = 1'b0; lut_target = 10'd116;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 116) begin
      errors++;
      $display("FAIL abs_branch: pc=%0d, want %0d (116)", prog_ctr, exp_pc_v);
    end
    tick();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 117) begin
      errors++;
      $display("FAIL abs_branch_next: pc=%0d, want %0d (117)", prog_ctr, exp_pc_v);
    end
  endtask

  task automatic test_rel_branch();
    jump_to(4);
    branch_en = 1'b1; rel_mode = 1'b1; lut_target = 10'h3FF;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 3) begin
      errors++;
      $display("FAIL rel_minus1: pc=%0d, want %0d (3)", prog_ctr, exp_pc_v);
    end
    jump_to(2);
    branch_en = 1'b1; rel_mode = 1'b1; lut_target = 10'h3FB;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 1021) begin
      errors++;
      $display("FAIL rel_wrap: pc=%0d, want %0d (1021)", prog_ctr, exp_pc_v);
    end
    jump_to(1023);
    tick();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 0) begin
      errors++;
      $display("FAIL inc_wrap: pc=%0d, want %0d (0)", prog_ctr, exp_pc_v);
    end
  endtask

  task automatic test_priority();
    jump_to(20);
    stall = 1'b1; branch_en = 1'b1; lut_target = 10'd500;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 20 || running !== 1'b1) begin
      errors++;
      $display("FAIL stall_vs_branch: pc=%0d run=%0b, want pc=%0d run=1", prog_ctr, running, exp_pc_v);
    end
    halt_req = 1'b1; branch_en = 1'b1; lut_target = 10'd500;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 20 || done !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL halt_vs_branch: pc=%0d run=%0b done=%0b, want pc=%0d run=0 done=1",
               prog_ctr, running, done, exp_pc_v);
    end
    stall = 1'b1; branch_en = 1'b1; halt_req = 1'b1;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || done !== 1'b1) begin
      errors++;
      $display("FAIL halt_hold: pc=%0d done=%0b, want pc=%0d done=1", prog_ctr, done, exp_pc_v);
    end
    start = 1'b1;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != START_PC || done !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL restart: pc=%0d run=%0b done=%0b, want pc=%0d run=1 done=0",
               prog_ctr, running, done, exp_pc_v);
    end
  endtask

  task automatic test_reset_mid_run();
    jump_to(50);
    reset = 1'b1; start = 1'b1;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != START_PC || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: pc=%0d run=%0b done=%0b, want pc=%0d run=0 done=0",
               prog_ctr, running, done, exp_pc_v);
    end
    branch_en = 1'b1; lut_target = 10'd300; stall = 1'b1; halt_req = 1'b1;
    tick();
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores: pc=%0d run=%0b done=%0b, want pc=%0d run=0 done=0",
               prog_ctr, running, done, exp_pc_v);
    end
  endtask

`ifdef PC_LINK_EN
  task automatic test_link();
    clr();
    start = 1'b1;
    tick();
    jump_to(30);
    call_en = 1'b1; branch_en = 1'b1; lut_target = 10'd200;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 200) begin
      errors++;
      $display("FAIL call: pc=%0d, want %0d (200)", prog_ctr, exp_pc_v);
    end
    for (int i = 0; i < 3; i++) tick();
    ret_en = 1'b1; branch_en = 1'b1; lut_target = 10'd900;
    tick();
    clr();
    vectors++;
    if (prog_ctr !== exp_pc_v || exp_pc != 31) begin
      errors++;
      $display("FAIL ret: pc=%0d, want %0d (31)", prog_ctr, exp_pc_v);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      start      = ($urandom_range(0, 3) == 0);
      stall      = ($urandom_range(0, 5) == 0);
      branch_en  = ($urandom_range(0, 2) == 0);
      rel_mode   = $urandom_range(0, 1) == 1;
      halt_req   = ($urandom_range(0, 24) == 0);
      call_en    = ($urandom_range(0, 3) == 0);
      ret_en     = ($urandom_range(0, 9) == 0);
      lut_idx    = 4'($urandom_range(0, 15));
      lut_target = D'($urandom_range(0, MODULUS - 1));
      tick();
      vectors++;
      if (prog_ctr !== exp_pc_v || running !== exp_run || done !== exp_done) begin
        errors++;
        $display("FAIL random[%0d]: pc=%0d run=%0b done=%0b, want pc=%0d run=%0b done=%0b",
                 i, prog_ctr, running, done, exp_pc_v, exp_run, exp_done);
      end
      vectors++;
      if (lut_addr !== lut_idx) begin
        errors++;
        $display("FAIL lut_addr[%0d]: got %0d, want %0d", i, lut_addr, lut_idx);
      end
    end
    clr();
  endtask

  initial begin
    #1;
    test_reset();
    test_increment();
    test_abs_branch();
    test_rel_branch();
    test_priority();
    test_reset_mid_run();
`ifdef PC_LINK_EN
    test_link();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the single-cycle core; it is the consumer side of the branch-target lookup table. It drives a 4-bit table index and receives a D-bit target, then updates the program counter each cycle. Update options: increment, absolute jump, or PC-relative branch (modulo 2^D). A start/halt FSM brackets each program run, and the top level and testbench use its done flag.

Parameters:
D, 10, program counter and table-target width in bits
START_PC, 0, PC value loaded on reset and on every start

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a program run; sampled in IDLE or HALT only
stall  input  1  hold PC this cycle (RUN only)
branch_en  input  1  take a branch this cycle using the table target
rel_mode  input  1  1 = relative (pc + target), 0 = absolute (target)
lut_idx  input  4  table index for the branch, from the instruction field
halt_req  input  1  program-end instruction executing
lut_addr  output  4  index to the lookup table; combinationally equals lut_idx
lut_target  input  D  target returned by the table (combinational, same cycle)
prog_ctr  output  D  current program counter (registered)
running  output  1  high in RUN
done  output  1  high in HALT

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. Reset has highest priority in every state.
- Reset values: state = IDLE, prog_ctr = START_PC, running = 0, done = 0. Reset during RUN aborts the run immediately; prog_ctr = START_PC on the next edge.
- FSM states are IDLE, RUN and HALT.
  - IDLE: on start, go to RUN and load prog_ctr = START_PC. Otherwise stay in IDLE and hold prog_ctr.
  - RUN: priority is halt_req > stall > branch_en > increment.
    - halt_req: go to HALT; prog_ctr holds the current value (the halting instruction's address).
    - stall: hold prog_ctr.
    - branch_en and rel_mode = 0: prog_ctr <= lut_target.
    - branch_en and rel_mode = 1: prog_ctr <= (prog_ctr + lut_target) mod 2^D. lut_target is two's complement, so all-ones means -1.
    - Otherwise: prog_ctr <= prog_ctr + 1 mod 2^D.
    - start is ignored in RUN.
  - HALT: done = 1 and prog_ctr holds. On start, go to RUN and load prog_ctr = START_PC; done falls the same edge.
- Latency: a branch or increment decided in cycle n is visible on prog_ctr in cycle n+1. lut_addr has zero-cycle latency.
- Wrap-around: increment from 2^D-1 gives 0. A relative result outside [0, 2^D-1] is truncated to D bits with no error flag.
- Simultaneous events:
  - halt_req with branch_en: halt wins and the branch is dropped.
  - stall with branch_en: the branch is dropped; the decoder must reassert it.
  - start with reset: reset wins.
- Outside RUN, the inputs stall, branch_en and halt_req are ignored.

Optional Feature:
Macro PC_LINK_EN adds a one-entry link register for call and return.
- With the macro, ports call_en (in, 1) and ret_en (in, 1) exist.
  - call_en with branch_en in RUN stores link <= prog_ctr + 1 mod 2^D and performs the branch.
  - ret_en (without halt_req or stall) sets prog_ctr <= link; ret_en has priority over branch_en.
  - link resets to START_PC. A second call overwrites link; there is no stack.
- Without the macro, the ports and the link register are absent and behaviour is exactly as above.

Test Plan:
- Reset then start with D=10, START_PC=0, no branches, 5 cycles -> prog_ctr steps 0,1,2,3,4,5; running=1, done=0.
- Absolute branch: at pc=7, branch_en=1, rel_mode=0, table target=116 -> next cycle prog_ctr=116, then 117.
- Relative branch wrap: at pc=4, rel_mode=1, target=10'h3FF (-1) -> prog_ctr=3. At pc=2, target=10'h3FB (-5) -> prog_ctr=1021. Also run pc=1023 with no branch -> 0.
- Priority: at pc=20, assert stall+branch_en -> pc stays 20. Then halt_req+branch_en -> HALT, done=1, pc stays 20. Then start -> RUN with pc=0, done=0.
- Reset mid-run: at pc=50 in RUN, assert reset for 1 cycle -> IDLE, pc=0, running=0. start ignored while reset is high. Branch inputs in IDLE leave pc=0.
- PC_LINK_EN: at pc=30, call_en+branch_en, absolute target=200 -> pc=200, link=31. Three increments, then ret_en -> pc=31.
